// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Defining PISO_PARITY_EN widens the bit counter to hold WIDTH+1 values.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
`ifdef PISO_PARITY_EN
    return $clog2(width + 1);
`else
    return $clog2(width);
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter that clears on load and saturates at LIMIT.
// The terminal-count flag tc is high while the count equals LIMIT.
module piso_bit_counter #(
  parameter int CNT_W = 2,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rs,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LIMIT_V);

  // Saturating at LIMIT keeps the count from wrapping if en stays high.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the serial delay line D input.
// Defining PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             last_bit;
  logic             cnt_clear;
  logic             data_bit;

  // last_bit marks the final data bit of the frame.
  piso_bit_counter #(
    .CNT_W (CNT_W),
    .LIMIT (WIDTH - 1)
  ) u_bit_counter (
    .clk  (clk),
    .rs   (rs),
    .load (cnt_clear),
    .en   (state == SHIFT),
    .tc   (last_bit)
  );

  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          din_ready  = 1'b1;
          state_next = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        din_ready  = 1'b1;
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
    accept = din_valid && din_ready;
    if (accept) begin
      state_next = SHIFT;
    end
    cnt_clear = accept || (state_next != SHIFT);
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Clearing shreg on the way to IDLE guarantees sout idles low.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= din;
    end else if (state_next == IDLE) begin
      shreg <= '0;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  assign data_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

`ifdef PISO_PARITY_EN
  logic parity_q;

  // Parity is captured at accept so later din changes cannot disturb it.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^din;
    end
  end

  assign sout = (state == PARITY) ? parity_q : data_bit;
`else
  assign sout = data_bit;
`endif

  assign sout_valid = (state != IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers against a bit-queue model.
// Build with PISO_PARITY_EN defined to cover the parity-frame variant.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rs;
  logic         din_valid;
  logic [W-1:0] din;

  logic m_ready, m_sout, m_valid, m_busy;
  logic l_ready, l_sout, l_valid, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rs         (rs),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (m_ready),
    .sout       (m_sout),
    .sout_valid (m_valid),
    .busy       (m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rs         (rs),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (l_ready),
    .sout       (l_sout),
    .sout_valid (l_valid),
    .busy       (l_busy)
  );

  // Model: each queue holds the bits still to appear on sout, head = current bit.
  // A word is taken when at most the final bit of a frame remains.
  always @(posedge clk or posedge rs) begin : model
    bit acc;
    if (rs) begin
      q_m.delete();
      q_l.delete();
    end else begin
      acc = din_valid && (q_m.size() <= 1);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(din[W-1-i]);
          q_l.push_back(din[i]);
        end
        if (FRAME_LEN > W) begin
          q_m.push_back(^din);
          q_l.push_back(^din);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("msb_sout",  m_sout,  (q_m.size() > 0) ? q_m[0] : 1'b0);
    checkOutput("msb_valid", m_valid, q_m.size() > 0);
    checkOutput("msb_busy",  m_busy,  q_m.size() > 0);
    checkOutput("msb_ready", m_ready, q_m.size() <= 1);
    checkOutput("lsb_sout",  l_sout,  (q_l.size() > 0) ? q_l[0] : 1'b0);
    checkOutput("lsb_valid", l_valid, q_l.size() > 0);
    checkOutput("lsb_busy",  l_busy,  q_l.size() > 0);
    checkOutput("lsb_ready", l_ready, q_l.size() <= 1);
  endtask

  // Each call checks the settled outputs, then drives the inputs for the next edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkAll();
      din_valid = v;
      din       = d;
    end
  endtask

  initial begin
    rs        = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sout",  m_sout,  1'b0);
    checkOutput("reset_valid", m_valid, 1'b0);
    checkOutput("reset_busy",  m_busy,  1'b0);
    rs = 1'b0;

    $display("[TB] single word 1011");
    applyStimulus(1'b1, 4'b1011, 1);
    applyStimulus(1'b0, 4'b0000, 7);

    $display("[TB] back-to-back 1011 then 0110");
    applyStimulus(1'b1, 4'b1011, 1);
    applyStimulus(1'b1, 4'b0110, FRAME_LEN);
    applyStimulus(1'b0, 4'b0000, 7);

    $display("[TB] word offered while busy");
    applyStimulus(1'b1, 4'b1011, 1);
    applyStimulus(1'b0, 4'b0000, 1);
    applyStimulus(1'b1, 4'b0001, FRAME_LEN - 1);
    applyStimulus(1'b0, 4'b1111, 8);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 4'b1011, 1);
    applyStimulus(1'b0, 4'b0000, 2);
    #2 rs = 1'b1;
    #1;
    checkOutput("midrst_msb_sout",  m_sout,  1'b0);
    checkOutput("midrst_msb_valid", m_valid, 1'b0);
    checkOutput("midrst_msb_busy",  m_busy,  1'b0);
    checkOutput("midrst_lsb_sout",  l_sout,  1'b0);
    checkOutput("midrst_lsb_valid", l_valid, 1'b0);
    checkOutput("midrst_lsb_busy",  l_busy,  1'b0);
    checkAll();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    rs = 1'b0;
    applyStimulus(1'b1, 4'b1100, 1);
    applyStimulus(1'b0, 4'b0000, 7);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), 1);
    end
    applyStimulus(1'b0, 4'b0000, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
